// File: rtl/store_queue.sv
// Circular store queue: allocates at tail, answers load lookups, drains committed stores head first.
// Build option STORE_FWD_EN: forward bytes to loads; when undefined, any matching older store stalls the load.
module store_queue #(
    parameter int SQ_DEPTH = 8,
    parameter int SQ_IDX   = 3,
    parameter int XLEN     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_en,
    output logic              alloc_ready,
    output logic [SQ_IDX-1:0] sq_tail,
    input  logic              exec_valid,
    input  logic [SQ_IDX-1:0] exec_idx,
    input  logic [XLEN-1:0]   exec_addr,
    input  logic [XLEN-1:0]   exec_data,
    input  logic [3:0]        exec_usebytes,
    input  logic              commit_en,
    input  logic              squash,
    input  logic [XLEN-1:0]   ld_addr,
    input  logic [SQ_IDX-1:0] ld_tail_pos,
    output logic              ld_stall,
    output logic [3:0]        ld_usebytes,
    output logic [XLEN-1:0]   ld_data,
    output logic              mem_wr_en,
    output logic [XLEN-1:0]   mem_wr_addr,
    output logic [XLEN-1:0]   mem_wr_data,
    output logic [3:0]        mem_wr_bytes,
    input  logic              mem_wr_ack
);
    localparam int PW = SQ_IDX + 1;

    typedef enum logic {S_IDLE, S_WRITE} drain_state_t;

    logic [SQ_IDX:0]     head, commit_ptr, tail, commit_nxt;
    logic [SQ_IDX-1:0]   head_idx, commit_idx, tail_idx;
    logic                full, alloc_fire, drain_done;
    drain_state_t        state;

    logic [SQ_DEPTH-1:0] e_valid, e_known, e_comm, squash_kill;
    logic [XLEN-3:0]     e_word  [SQ_DEPTH];
    logic [XLEN-1:0]     e_data  [SQ_DEPTH];
    logic [3:0]          e_bytes [SQ_DEPTH];
    logic                unused_addr_lsbs;

    assign head_idx    = head[SQ_IDX-1:0];
    assign commit_idx  = commit_ptr[SQ_IDX-1:0];
    assign tail_idx    = tail[SQ_IDX-1:0];
    assign full        = (head_idx == tail_idx) && (head[SQ_IDX] != tail[SQ_IDX]);
    assign alloc_ready = !full;
    assign sq_tail     = tail_idx;
    assign alloc_fire  = alloc_en && !full && !squash;
    assign drain_done  = mem_wr_en && mem_wr_ack;
    assign commit_nxt  = commit_ptr + PW'(commit_en);
    assign unused_addr_lsbs = ^{exec_addr[1:0], ld_addr[1:0]};

    // An entry committing in the same cycle as a squash survives it.
    always_comb begin
        squash_kill = '0;
        for (int i = 0; i < SQ_DEPTH; i++)
            squash_kill[i] = squash && e_valid[i] && !e_comm[i] &&
                             !(commit_en && commit_idx == SQ_IDX'(i));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            commit_ptr <= '0;
            tail       <= '0;
            e_valid    <= '0;
            e_known    <= '0;
            e_comm     <= '0;
        end else begin
            commit_ptr <= commit_nxt;
            tail       <= squash ? commit_nxt : tail + PW'(alloc_fire);
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (drain_done && head_idx == SQ_IDX'(i)) begin
                    e_valid[i] <= 1'b0;
                    e_known[i] <= 1'b0;
                    e_comm[i]  <= 1'b0;
                end else if (squash_kill[i]) begin
                    e_valid[i] <= 1'b0;
                    e_known[i] <= 1'b0;
                end else begin
                    if (alloc_fire && tail_idx == SQ_IDX'(i)) begin
                        e_valid[i] <= 1'b1;
                        e_known[i] <= 1'b0;
                        e_comm[i]  <= 1'b0;
                    end
                    if (exec_valid && exec_idx == SQ_IDX'(i))
                        e_known[i] <= 1'b1;
                    if (commit_en && commit_idx == SQ_IDX'(i))
                        e_comm[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (exec_valid && !squash_kill[exec_idx]) begin
            e_word[exec_idx]  <= exec_addr[XLEN-1:2];
            e_data[exec_idx]  <= exec_data;
            e_bytes[exec_idx] <= exec_usebytes;
        end
    end

    // Drain: IDLE sees a committed head, WRITE holds the request until the cache acks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            mem_wr_en <= 1'b0;
            head      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (e_valid[head_idx] && e_comm[head_idx]) begin
                        state     <= S_WRITE;
                        mem_wr_en <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_wr_ack) begin
                        state     <= S_IDLE;
                        mem_wr_en <= 1'b0;
                        head      <= head + PW'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign mem_wr_addr  = {e_word[head_idx], 2'b00};
    assign mem_wr_data  = e_data[head_idx];
    assign mem_wr_bytes = e_bytes[head_idx];

    logic [SQ_IDX-1:0] lim, idx;
    logic              stall;
`ifdef STORE_FWD_EN
    logic [3:0]        fwd_bytes;
    logic [XLEN-1:0]   fwd_data;
`else
    logic              hit;
`endif

    // Walk oldest to youngest by distance from head so younger matches override older ones.
    always_comb begin
        lim   = ld_tail_pos - head_idx;
        idx   = '0;
        stall = 1'b0;
`ifdef STORE_FWD_EN
        fwd_bytes = '0;
        fwd_data  = '0;
`else
        hit = 1'b0;
`endif
        for (int k = 0; k < SQ_DEPTH; k++) begin
            idx = head_idx + SQ_IDX'(k);
            if (SQ_IDX'(k) < lim && e_valid[idx]) begin
                if (!e_known[idx]) begin
                    stall = 1'b1;
                end else if (e_word[idx] == ld_addr[XLEN-1:2]) begin
`ifdef STORE_FWD_EN
                    for (int b = 0; b < 4; b++) begin
                        if (e_bytes[idx][b]) begin
                            fwd_bytes[b]       = 1'b1;
                            fwd_data[8*b +: 8] = e_data[idx][8*b +: 8];
                        end
                    end
`else
                    hit = 1'b1;
`endif
                end
            end
        end
    end

`ifdef STORE_FWD_EN
    assign ld_stall    = stall;
    assign ld_usebytes = stall ? 4'b0000 : fwd_bytes;
    assign ld_data     = stall ? '0 : fwd_data;
`else
    assign ld_stall    = stall || hit;
    assign ld_usebytes = 4'b0000;
    assign ld_data     = '0;
`endif

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: queue-of-stores reference model, write-back scoreboard and randomized traffic.
module tb_store_queue;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        alloc_en, alloc_ready;
    logic [2:0]  sq_tail;
    logic        exec_valid;
    logic [2:0]  exec_idx;
    logic [31:0] exec_addr, exec_data;
    logic [3:0]  exec_usebytes;
    logic        commit_en, squash;
    logic [31:0] ld_addr;
    logic [2:0]  ld_tail_pos;
    logic        ld_stall;
    logic [3:0]  ld_usebytes;
    logic [31:0] ld_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_bytes;
    logic        mem_wr_ack;

    always #5 clock = ~clock;

    store_queue dut (
        .clock(clock), .reset(reset),
        .alloc_en(alloc_en), .alloc_ready(alloc_ready), .sq_tail(sq_tail),
        .exec_valid(exec_valid), .exec_idx(exec_idx), .exec_addr(exec_addr),
        .exec_data(exec_data), .exec_usebytes(exec_usebytes),
        .commit_en(commit_en), .squash(squash),
        .ld_addr(ld_addr), .ld_tail_pos(ld_tail_pos),
        .ld_stall(ld_stall), .ld_usebytes(ld_usebytes), .ld_data(ld_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_bytes(mem_wr_bytes), .mem_wr_ack(mem_wr_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          known;
        bit          comm;
    } st_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    st_t         q[$];        // in-flight stores, oldest first
    wr_t         exp_wr[$];   // write-backs owed to the cache, in order
    int          head_idx, nc, drained;
    logic [31:0] last_wr_addr;
    int          checks, errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_lookup(input logic [31:0] la, input logic [2:0] lt,
                                         output bit st, output logic [3:0] ub, output logic [31:0] d);
        int lim;
        bit hit;
        lim = (int'(lt) - head_idx + 8) % 8;
        st = 0; hit = 0; ub = '0; d = '0;
        for (int k = 0; k < lim && k < q.size(); k++) begin
            if (!q[k].known) st = 1;
            else if (q[k].addr[31:2] == la[31:2]) begin
                hit = 1;
                for (int b = 0; b < 4; b++)
                    if (q[k].be[b]) begin
                        ub[b] = 1'b1;
                        d[8*b +: 8] = q[k].data[8*b +: 8];
                    end
            end
        end
`ifdef STORE_FWD_EN
        if (st) begin ub = '0; d = '0; end
`else
        st = st | hit;
        ub = '0;
        d  = '0;
`endif
    endfunction

    // One clock: check state, drive inputs, check lookup, advance the model. Returns at negedge+4.
    task automatic step(input bit al, input bit ex, input int exk, input logic [31:0] exa,
                        input logic [31:0] exd, input logic [3:0] exb, input bit cm, input bit sq,
                        input logic [31:0] la, input logic [2:0] lt, input bit ack);
        bit st;
        logic [3:0] ub;
        logic [31:0] d;
        st_t e;
        wr_t w;
        @(negedge clock);
        #1;
        check("alloc_ready", 32'(alloc_ready), 32'(q.size() < 8));
        check("sq_tail", 32'(sq_tail), 32'((head_idx + q.size()) % 8));
        alloc_en = al; exec_valid = ex; exec_idx = 3'((head_idx + exk) % 8);
        exec_addr = exa; exec_data = exd; exec_usebytes = exb;
        commit_en = cm; squash = sq; ld_addr = la; ld_tail_pos = lt; mem_wr_ack = ack;
        #1;
        model_lookup(la, lt, st, ub, d);
        check("ld_stall", 32'(ld_stall), 32'(st));
        check("ld_usebytes", 32'(ld_usebytes), 32'(ub));
        check("ld_data", ld_data, d);
        if (ex) begin
            q[exk].addr = exa; q[exk].data = exd; q[exk].be = exb; q[exk].known = 1;
        end
        if (cm) begin
            w.addr = {q[nc].addr[31:2], 2'b00}; w.data = q[nc].data; w.be = q[nc].be;
            exp_wr.push_back(w);
            q[nc].comm = 1;
            nc++;
        end
        if (sq) begin
            while (q.size() > nc) q.delete(q.size() - 1);
        end else if (al && q.size() < 8) begin
            e.addr = '0; e.data = '0; e.be = '0; e.known = 0; e.comm = 0;
            q.push_back(e);
        end
        #2;
    endtask

    task automatic idle(input bit ack);
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h300, 3'd0, ack);
    endtask
    task automatic alloc1();
        step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h300, 3'd0, 0);
    endtask
    task automatic exec1(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        step(0, 1, k, a, d, b, 0, 0, 32'h300, 3'd0, 0);
    endtask
    task automatic commit1();
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h300, 3'd0, 0);
    endtask

    task automatic drain_all(input int limit);
        for (int i = 0; i < limit && exp_wr.size() > 0; i++) idle(1'b1);
        check("drain_complete", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 0;
        alloc_en = 0; exec_valid = 0; exec_idx = '0; exec_addr = '0; exec_data = '0;
        exec_usebytes = '0; commit_en = 0; squash = 0; ld_addr = 32'h100;
        ld_tail_pos = 3'd3; mem_wr_ack = 0;
        q.delete(); exp_wr.delete(); head_idx = 0; nc = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        #1;
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_sq_tail", 32'(sq_tail), 32'd0);
        check("rst_ld_stall", 32'(ld_stall), 32'd0);
        check("rst_ld_usebytes", 32'(ld_usebytes), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        #3;
    endtask

    task automatic rand_step();
        int sz, exk;
        int unk[$];
        bit al, ex, cm, sq, ack;
        logic [2:0] lt;
        sz = q.size();
        for (int k = 0; k < sz; k++) if (!q[k].known) unk.push_back(k);
        al  = ($urandom % 2) == 1;
        ex  = unk.size() > 0 && ($urandom % 2) == 1;
        exk = ex ? unk[$urandom % unk.size()] : 0;
        cm  = nc < sz && q[nc].known && ($urandom % 3) == 0;
        sq  = ($urandom % 50) == 0;
        ack = ($urandom % 2) == 1;
        lt  = 3'((head_idx + int'($urandom_range(0, sz))) % 8);
        step(al, ex, exk, 32'h100 + $urandom_range(0, 15), $urandom, 4'($urandom_range(1, 15)),
             cm, sq, 32'h100 + 4 * $urandom_range(0, 3), lt, ack);
    endtask

    // Scoreboard: every accepted write-back must match the oldest owed store.
    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge clock);
            #3;
            if (reset && mem_wr_en && mem_wr_ack) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got write to 0x%0h, expected none", mem_wr_addr);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", mem_wr_addr, w.addr);
                    check("wr_data", mem_wr_data, w.data);
                    check("wr_bytes", 32'(mem_wr_bytes), 32'(w.be));
                end
                last_wr_addr = mem_wr_addr;
                drained++;
                if (q.size() > 0) begin
                    q.delete(0);
                    if (nc > 0) nc--;
                    head_idx = (head_idx + 1) % 8;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; drained = 0; head_idx = 0; nc = 0; last_wr_addr = '0;
        do_reset();

        // Unknown-address stall
        alloc1();
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h300, 3'd1, 0);
        check("stall_unknown", 32'(ld_stall), 32'd1);
        exec1(0, 32'h100, 32'h12345678, 4'hF);
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h300, 3'd1, 0);
        check("stall_known", 32'(ld_stall), 32'd0);

        // Byte merge
        do_reset();
        alloc1(); alloc1();
        exec1(0, 32'h105, 32'h0000AB00, 4'b0010);
        exec1(1, 32'h104, 32'h11223344, 4'b1111);
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h104, 3'd1, 0);
`ifdef STORE_FWD_EN
        check("merge1_bytes", 32'(ld_usebytes), 32'h2);
        check("merge1_data", ld_data, 32'h0000AB00);
`else
        check("merge1_stall", 32'(ld_stall), 32'd1);
        check("merge1_bytes", 32'(ld_usebytes), 32'h0);
`endif
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h104, 3'd2, 0);
`ifdef STORE_FWD_EN
        check("merge2_bytes", 32'(ld_usebytes), 32'hF);
        check("merge2_data", ld_data, 32'h11223344);
`else
        check("merge2_stall", 32'(ld_stall), 32'd1);
        check("merge2_bytes", 32'(ld_usebytes), 32'h0);
`endif
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h104, 3'd2, 0);
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h104, 3'd2, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++)
            step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h104, 3'd2, 1);
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h104, 3'd2, 0);
        check("merge_drained_stall", 32'(ld_stall), 32'd0);
        check("merge_drained_bytes", 32'(ld_usebytes), 32'd0);

        // Fill and wrap
        do_reset();
        for (int i = 0; i < 8; i++) alloc1();
        idle(0);
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        alloc1();
        idle(0);
        check("full_sq_tail", 32'(sq_tail), 32'd0);
        exec1(0, 32'h100, 32'hA5A5A5A5, 4'hF);
        exec1(1, 32'h109, 32'h00005A00, 4'b0010);
        commit1(); commit1();
        drain_all(30);
        alloc1(); alloc1();
        idle(0);
        check("wrap_sq_tail", 32'(sq_tail), 32'd2);
        check("wrap_full", 32'(alloc_ready), 32'd0);

        // Squash
        do_reset();
        drained = 0;
        alloc1(); alloc1(); alloc1();
        exec1(0, 32'h202, 32'h00BE0000, 4'b0100);
        commit1();
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h300, 3'd0, 0);
        idle(0);
        check("squash_sq_tail", 32'(sq_tail), 32'd1);
        drain_all(20);
        repeat (4) idle(1);
        check("squash_drains", 32'(drained), 32'd1);
        check("squash_wr_addr", last_wr_addr, 32'h200);

        // Reset mid-drain
        do_reset();
        alloc1();
        exec1(0, 32'h10C, 32'hDEADBEEF, 4'hF);
        commit1();
        for (int i = 0; i < 10 && !mem_wr_en; i++) idle(0);
        @(negedge clock);
        check("pre_reset_wr_en", 32'(mem_wr_en), 32'd1);
        reset = 0;
        #1;
        check("async_wr_en", 32'(mem_wr_en), 32'd0);
        check("async_sq_tail", 32'(sq_tail), 32'd0);
        check("async_alloc_ready", 32'(alloc_ready), 32'd1);
        q.delete(); exp_wr.delete(); head_idx = 0; nc = 0;
        repeat (2) @(negedge clock);
        reset = 1;

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) rand_step();
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h300, 3'd0, 0);
        drain_all(100);
        check("final_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
